// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory read path.
//   DM_WORDS        : number of 32-bit words in the data memory (4KB).
//   LOAD_*          : req_type encodings understood by the load unit.
//   dm_state_t      : control states of dm_load_unit.
//   is_known_load() : true for the five legal req_type codes.
// ---------------------------------------------------------------------------
package dm_pkg;

  localparam int DM_WORDS = 1024;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ERR_RESP = 3'd3,
    ST_RESP     = 3'd4
  } dm_state_t;

  // Codes 011, 110 and 111 are reserved and always rejected.
  function automatic logic is_known_load(input logic [2:0] load_type);
    return (load_type == LOAD_LB)  || (load_type == LOAD_LH)  ||
           (load_type == LOAD_LW)  || (load_type == LOAD_LBU) ||
           (load_type == LOAD_LHU);
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// ---------------------------------------------------------------------------
// dm_load_align
// Purely combinational little-endian extraction of a load result from a
// 32-bit memory word, plus the legality check for the request.
// Ports:
//   word        in  32  memory word containing the addressed data
//   byte_offset in  2   byte address bits [1:0]
//   load_type   in  3   lb/lh/lw/lbu/lhu encoding (see dm_pkg)
//   data        out 32  extracted and sign/zero-extended result (0 if illegal)
//   illegal     out 1   misaligned address or unknown load type
// The illegal flag depends only on byte_offset and load_type, so the unit can
// evaluate legality at accept time without a valid memory word.
// ---------------------------------------------------------------------------
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane and halfword lane out of the word.
  always_comb begin
    byte_sel = word[7:0];
    case (byte_offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = byte_offset[1] ? word[31:16] : word[15:0];
  end

  // Extend according to the load type; any illegal request yields zero data
  // so an error response never carries stale memory contents.
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (load_type)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'd0, byte_sel};
      LOAD_LH: begin
        illegal = byte_offset[0];
        data    = {{16{half_sel[15]}}, half_sel};
      end
      LOAD_LHU: begin
        illegal = byte_offset[0];
        data    = {16'd0, half_sel};
      end
      LOAD_LW: begin
        illegal = |byte_offset;
        data    = word;
      end
      default: begin
        illegal = 1'b1;
        data    = '0;
      end
    endcase
    if (illegal || !is_known_load(load_type)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/dm_load_unit.sv
// ---------------------------------------------------------------------------
// dm_load_unit
// Read-side controller for the 1024 x 32-bit data memory. Accepts one load
// at a time, performs a single synchronous word read, extracts/extends the
// result and returns it on a valid/ready response channel.
// Parameters:
//   ADDR_BITS   byte-address bits used (upper request bits ignored, 4KB wrap)
//   INDEX_BITS  width of the memory word index
// Ports:
//   clock, reset    single clock, synchronous active-high reset
//   req_valid/ready load request handshake
//   req_address     byte address of the load
//   req_type        lb/lh/lw/lbu/lhu encoding
//   resp_valid/ready response handshake
//   resp_data       extracted load result
//   resp_error      misaligned address or illegal type
//   mem_read_en     one-cycle read strobe to the data memory
//   mem_read_index  word index of the latched address
//   mem_read_data   memory word, valid the cycle after mem_read_en
// ---------------------------------------------------------------------------
module dm_load_unit
  import dm_pkg::*;
#(
  parameter int ADDR_BITS  = 12,
  parameter int INDEX_BITS = ADDR_BITS - 2
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_address,
  input  logic [2:0]            req_type,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic                  mem_read_en,
  output logic [INDEX_BITS-1:0] mem_read_index,
  input  logic [31:0]           mem_read_data
);

  dm_state_t             state;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [2:0]            type_q;
  logic                  accept;
  logic [1:0]            align_offset;
  logic [2:0]            align_type;
  logic [31:0]           align_data;
  logic                  align_illegal;
  logic                  unused_addr_bits;

  // Address bits above the 4KB window deliberately have no effect.
  assign unused_addr_bits = ^req_address[31:ADDR_BITS];

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // The latched address drives the read index directly, so the index is
  // stable from accept until the next accept and zero after reset.
  assign mem_read_index = addr_q[ADDR_BITS-1:2];

  // One aligner serves both jobs: in IDLE it judges the incoming request,
  // afterwards it works on the latched request and the returned word.
  assign align_offset = (state == ST_IDLE) ? req_address[1:0] : addr_q[1:0];
  assign align_type   = (state == ST_IDLE) ? req_type         : type_q;

  dm_load_align u_align (
    .word        (mem_read_data),
    .byte_offset (align_offset),
    .load_type   (align_type),
    .data        (align_data),
    .illegal     (align_illegal)
  );

  // Control FSM with registered outputs. mem_read_en is raised on the accept
  // edge so it is high exactly while in ISSUE. In RESP the first cycle lets
  // the registered result settle; resp_valid rises on the following edge and
  // stays up, with data and error frozen, until the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      type_q      <= LOAD_LB;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
      mem_read_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= req_address[ADDR_BITS-1:0];
            type_q <= req_type;
            if (align_illegal) begin
              state <= ST_ERR_RESP;
            end else begin
              state       <= ST_ISSUE;
              mem_read_en <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          mem_read_en <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_data  <= align_data;
          resp_error <= 1'b0;
          state      <= ST_RESP;
        end
        ST_ERR_RESP: begin
          resp_data  <= '0;
          resp_error <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          mem_read_en <= 1'b0;
          resp_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// ---------------------------------------------------------------------------
// tb_dm_load_unit
// Self-checking bench for dm_load_unit: table of directed loads, hand-built
// reset/backpressure sequences and randomized loads against a reference model.
// ---------------------------------------------------------------------------
module tb_dm_load_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [2:0]  req_type;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        mem_read_en;
  logic [9:0]  mem_read_index;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  dm_load_unit dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_address    (req_address),
    .req_type       (req_type),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_error     (resp_error),
    .mem_read_en    (mem_read_en),
    .mem_read_index (mem_read_index),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory; outside a read the bus carries junk so any
  // use of it outside the data phase shows up as wrong results.
  always @(posedge clock) begin
    if (mem_read_en) mem_read_data <= mem[mem_read_index];
    else             mem_read_data <= $urandom;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference load semantics from plain arithmetic on the little-endian word.
  function automatic void refLoad(input logic [31:0] word, input logic [31:0] addr,
                                  input logic [2:0] ltype,
                                  output logic [31:0] d, output logic e);
    int unsigned w, lane, b, h;
    w    = word;
    lane = addr % 4;
    b    = (w >> (8 * lane)) % 256;
    h    = (w >> (16 * ((addr / 2) % 2))) % 65536;
    d    = 32'd0;
    e    = 1'b0;
    case (ltype)
      3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: d = b;
      3'd1: if (addr % 2 != 0) e = 1'b1; else d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: if (addr % 2 != 0) e = 1'b1; else d = h;
      3'd2: if (lane != 0) e = 1'b1; else d = w;
      default: e = 1'b1;
    endcase
  endfunction

  // One complete load: present request, watch the read strobe and response
  // latency, hold off the response for 'stall' cycles, then hand it off.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] ltype,
                               input int stall, input logic [31:0] exp_data,
                               input logic exp_err);
    int  n;
    int  lat;
    int  en_count;
    logic [9:0] idx_seen;
    bit  seen;
    req_valid   = 1'b1;
    req_address = addr;
    req_type    = ltype;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid   = 1'b0;
    req_address = $urandom;
    req_type    = 3'($urandom);
    en_count = 0;
    idx_seen = '0;
    seen     = 1'b0;
    lat      = 0;
    for (int c = 0; c <= 20 && !seen; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (mem_read_en) begin
        en_count++;
        idx_seen = mem_read_index;
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput("resp_latency", lat, exp_err ? 32'd2 : 32'd3);
    checkOutput("mem_read_en_cycles", en_count, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) checkOutput("mem_read_index", {22'd0, idx_seen}, (addr >> 2) % 1024);
    checkOutput("resp_data", resp_data, exp_data);
    checkOutput("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      checkOutput("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("stall_resp_data", resp_data, exp_data);
      checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checkOutput("handoff_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("handoff_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  vec_t vecs [12];

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] up;
    logic [9:0]  idx;
    logic [1:0]  off;
    logic [2:0]  t;
    int          quiet;

    vecs[0]  = '{32'h0000_000C, 3'b010, 32'h8899_AABB, 1'b0};
    vecs[1]  = '{32'h0000_0001, 3'b000, 32'h0000_007F, 1'b0};
    vecs[2]  = '{32'h0000_0002, 3'b000, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h0000_0003, 3'b100, 32'h0000_0080, 1'b0};
    vecs[4]  = '{32'h0000_0002, 3'b001, 32'hFFFF_80FF, 1'b0};
    vecs[5]  = '{32'h0000_0000, 3'b101, 32'h0000_7F01, 1'b0};
    vecs[6]  = '{32'h0000_0006, 3'b010, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h0000_0003, 3'b001, 32'h0000_0000, 1'b1};
    vecs[8]  = '{32'h0000_0000, 3'b011, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'hFFFF_F004, 3'b010, 32'h1234_5678, 1'b0};
    vecs[10] = '{32'h0000_1002, 3'b101, 32'h0000_80FF, 1'b0};
    vecs[11] = '{32'h0000_0010, 3'b111, 32'h0000_0000, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h80FF_7F01;
    mem[1] = 32'h1234_5678;
    mem[3] = 32'h8899_AABB;

    // Reset with a request pending: nothing may be accepted or issued.
    reset       = 1'b1;
    req_valid   = 1'b1;
    req_address = 32'h0000_000C;
    req_type    = 3'b010;
    resp_ready  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("reset_mem_read_en", {31'd0, mem_read_en}, 32'd0);
      checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset_resp_data", resp_data, 32'd0);
      checkOutput("reset_resp_error", {31'd0, resp_error}, 32'd0);
      checkOutput("reset_mem_read_index", {22'd0, mem_read_index}, 32'd0);
    end
    req_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clock); #1;
    checkOutput("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Directed table; stall varies so some entries exercise backpressure.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].ltype, i % 3, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Long backpressure on a normal load.
    applyStimulus(32'h0000_000C, 3'b010, 5, 32'h8899_AABB, 1'b0);

    // Reset while the read data is in flight: the response must vanish.
    req_valid   = 1'b1;
    req_address = 32'h0000_000C;
    req_type    = 3'b010;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("midop_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midop_reset_mem_read_en", {31'd0, mem_read_en}, 32'd0);
    checkOutput("midop_reset_req_ready", {31'd0, req_ready}, 32'd0);
    reset      = 1'b0;
    resp_ready = 1'b1;
    #1;
    checkOutput("midop_release_req_ready", {31'd0, req_ready}, 32'd1);
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      if (resp_valid || mem_read_en) quiet++;
    end
    resp_ready = 1'b0;
    checkOutput("midop_no_response", quiet, 32'd0);
    applyStimulus(32'h0000_0001, 3'b100, 0, 32'h0000_007F, 1'b0);

    // Randomized loads over the whole 32-bit address space.
    for (int i = 0; i < 60; i++) begin
      up  = $urandom;
      idx = 10'($urandom_range(0, 1023));
      off = 2'($urandom_range(0, 3));
      t   = 3'($urandom_range(0, 7));
      up  = {up[31:12], idx, off};
      refLoad(mem[idx], up, t, d, e);
      applyStimulus(up, t, $urandom_range(0, 2), d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
Read-side controller for the 4KB word-organised data memory (1024 x 32-bit, word index = byte address[11:2]).
- Accepts load requests from the pipeline over a valid/ready handshake.
- Issues one synchronous word read to the memory read port.
- Extracts and extends byte, halfword or word results (lb/lh/lw/lbu/lhu), and returns them over a valid/ready response channel with an error flag.
- Sits between the memory stage and the data memory; it is the reader counterpart to the memory's write port.

Parameters:
ADDR_BITS, 12, byte-address bits used; upper request address bits ignored (4KB wrap).
INDEX_BITS, ADDR_BITS-2, width of the memory word index.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  load request present.
req_ready  output  1  unit can accept a request.
req_address  input  32  byte address of the load.
req_type  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are illegal.
resp_valid  output  1  response present.
resp_ready  input  1  consumer accepts the response.
resp_data  output  32  extracted, extended load result.
resp_error  output  1  misaligned address or illegal req_type.
mem_read_en  output  1  read strobe to the data memory.
mem_read_index  output  INDEX_BITS  word index = latched address[ADDR_BITS-1:2].
mem_read_data  input  32  memory word, valid the cycle after mem_read_en.

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_data=0, resp_error=0, mem_read_en=0, mem_read_index=0. req_ready=0 while reset is high.
- req_ready = (state==IDLE) && !reset. Accept occurs on an edge with req_valid && req_ready. On accept, latch address[ADDR_BITS-1:0] and req_type.
- States:
  - IDLE: on accept, go to ERR_RESP if the request is illegal, else ISSUE.
  - ISSUE: mem_read_en=1, mem_read_index=latched index, for exactly one cycle. Next state WAIT.
  - WAIT: mem_read_data is valid. Register the extracted result into resp_data, set resp_error=0. Next state RESP.
  - ERR_RESP: set resp_data=0, resp_error=1, no memory read. Next state RESP.
  - RESP: resp_valid=1. resp_data and resp_error are held stable until resp_ready. On resp_valid && resp_ready, go to IDLE and clear resp_valid.
- Illegal request conditions:
  - req_type not in {000, 001, 010, 100, 101}.
  - lh/lhu with address[0]=1.
  - lw with address[1:0]!=0.
- Latency, from accept edge k:
  - Normal load: resp_valid high after edge k+3.
  - Error: resp_valid high after edge k+2.
- resp_ready is sampled only in RESP; a response is never dropped.
- No overlap: the next request can be accepted no earlier than the cycle after response handoff. Minimum request spacing is 4 cycles.
- Extraction, little-endian:
  - Byte lane b = address[1:0]; byte = word[8b+7:8b].
  - Halfword lane h = address[1]; half = word[16h+15:16h].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes the word through.
- Address wrap: bits above ADDR_BITS-1 have no effect (0x0000_1004 reads index 1).
- mem_read_en is never asserted outside ISSUE. mem_read_data is ignored outside WAIT.
- Reset mid-operation in any state: abort immediately, no response is produced, and in-flight memory data is discarded.
- X on req_address/req_type is ignored when req_valid=0.

Decomposition:
- Shared package dm_pkg holds:
  - Load-type constants LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU.
  - The state encoding (IDLE, ISSUE, WAIT, ERR_RESP, RESP).
  - DM_WORDS=1024.
- One sub-module, dm_load_align: purely combinational (word, addr[1:0], type) -> (data, misaligned/illegal flag). It is reused by the legality check and the WAIT-state extraction.

Test Plan:
- Reset and idle: hold reset 2 cycles with req_valid=1 -> req_ready=0, mem_read_en=0, resp_valid=0, resp_data=0. Release reset -> req_ready=1 next cycle.
- lw: mem word[3]=0x8899AABB; lw at 0x0C accepted at edge k -> mem_read_en=1 with index=3 for one cycle, resp_valid after k+3, resp_data=0x8899AABB, resp_error=0.
- Byte/half extension: word[0]=0x80FF7F01.
  - lb @0x1 -> 0x0000007F.
  - lb @0x2 -> 0xFFFFFFFF.
  - lbu @0x3 -> 0x00000080.
  - lh @0x2 -> 0xFFFF80FF.
  - lhu @0x0 -> 0x00007F01.
- Errors: lw @0x06, lh @0x03, and req_type=011 -> no mem_read_en, resp_valid after k+2, resp_error=1, resp_data=0.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout. Raise resp_ready -> handoff, IDLE, next request accepted the following cycle.
- Reset mid-op and wrap:
  - Assert reset during WAIT -> no response, state IDLE.
  - lw at 0xFFFF_F004 -> index=1.
